ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the team's single-port synchronous RAM. The RAM has 8-bit data, an 8-bit address, a write enable and a registered read output.
- The block does three things:
  - Shares the single RAM port between requester A and requester B, one access per cycle.
  - Returns read data to the requester that issued the read.
  - Runs a hardware clear sequence that writes zero to every address, replacing a bulk in-RAM reset.

Parameters:
- DATA_W, 8, data width of the RAM word.
- ADDR_W, 8, address width. DEPTH = 2**ADDR_W is a derived localparam, not overridable.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- a_req  in  1  requester A access request, held until granted
- a_we  in  1  requester A: 1=write, 0=read
- a_addr  in  ADDR_W  requester A address
- a_wdata  in  DATA_W  requester A write data
- a_gnt  out  1  A's access is issued to the RAM this cycle
- a_rvalid  out  1  A's read data valid on rdata
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid: same as the A ports, for requester B
- rdata  out  DATA_W  read data, shared; qualified by a_rvalid/b_rvalid
- clear_req  in  1  pulse: start a zero-fill of the whole RAM
- clear_busy  out  1  clear sequence in progress
- clear_done  out  1  one-cycle pulse when the clear completes
- mem_addr  out  ADDR_W  to RAM address
- mem_we  out  1  to RAM write_en
- mem_din  out  DATA_W  to RAM data_in
- mem_dout  in  DATA_W  from RAM data_out, valid the cycle after a read is issued

Behaviour:
- Reset is asynchronous and active-high; clk is the single clock.
- Reset values:
  - state=IDLE
  - last_grant=B, so A wins the first contention
  - clear counter=0
  - a_rvalid=b_rvalid=0, clear_busy=0, clear_done=0, rdata=0
- Combinational outputs while reset is high: a_gnt=b_gnt=0, mem_we=0, mem_addr=0, mem_din=0.
- FSM states: IDLE (serve requests) and CLEAR (zero-fill).
- IDLE:
  - clear_req=1 takes priority: no grant that cycle and state goes to CLEAR at the next edge.
  - Otherwise, at most one grant per cycle, combinational from req.
  - Only one requester active: it is granted.
  - Both active: the requester not in last_grant is granted.
  - last_grant updates on every grant.
- The granted requester's we/addr/wdata drive mem_we/mem_addr/mem_din in the same cycle, so the RAM samples them at that edge.
- A requester treats gnt=1 at a clock edge as acceptance and may change its request fields after that edge.
- Reads:
  - A granted read with we=0 sets a registered owner flag.
  - Next cycle, the owner's rvalid=1 and rdata=mem_dout; this is a latency of 1 cycle after gnt.
  - Back-to-back reads from alternating requesters give a continuous rvalid stream, one result per cycle, correctly steered.
- Writes: no rvalid is produced. The RAM output holds its previous value during a write, and the block must never assert rvalid for a write.
- CLEAR:
  - Each cycle drives mem_we=1, mem_din=0, mem_addr=counter, then increments the counter.
  - Runs for exactly DEPTH cycles, addresses 0..DEPTH-1.
  - clear_busy=1 for exactly those DEPTH cycles.
  - After the write to DEPTH-1: counter wraps to 0, state returns to IDLE, and clear_done=1 for one cycle, the first IDLE cycle.
  - Requests are not granted during CLEAR; requesters keep req held.
  - clear_req during CLEAR is ignored.
  - A read granted in the last IDLE cycle before CLEAR still returns its rvalid in the first CLEAR cycle.
- Reset mid-CLEAR aborts the sequence: no clear_done, RAM contents are undefined, state=IDLE.
- Reset mid-read drops the pending rvalid.
- Address arithmetic: the counter is ADDR_W bits and wraps modulo DEPTH. There is no address range check on requester addresses; all are in range by width.

Test Plan:
- Reset then a_req=1, a_we=1, a_addr=0x10, a_wdata=0x5A for 1 grant; then a_req read 0x10 -> a_gnt same cycle, a_rvalid=1 and rdata=0x5A exactly one cycle later; b_rvalid stays 0.
- A writes 0x20=0x11 and B writes 0x21=0x22 first; then a_req and b_req both held high reading 0x20 (A) and 0x21 (B) -> grants alternate A,B,A,B; rvalid/rdata alternate 0x11 (A), 0x22 (B) with no gaps and no misrouting.
- Continuous B-only reads -> b_gnt every cycle; a later simultaneous a_req is granted within 1 cycle (round-robin fairness).
- Fill addresses 0x00, 0x7F, 0xFF with 0xA5; pulse clear_req -> clear_busy high for exactly 256 cycles; no grants despite held requests; clear_done single pulse; reads of 0x00, 0x7F, 0xFF return 0x00.
- clear_req asserted again mid-clear -> ignored; busy length still 256. Read granted the cycle clear_req is sampled? None granted; read granted the cycle before -> rvalid still delivered.
- Assert reset asynchronously mid-clear (no clock edge) -> clear_busy, rvalid, grants and mem_we drop immediately; after release, A wins first contention.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for two requesters sharing one single-port synchronous RAM,
// with read-data steering and a hardware zero-fill sequence.
module ram_port_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] rdata,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            r_state;
  logic              r_last_b;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_pend_a;
  logic              r_pend_b;
  logic              r_done;
  logic              w_a_gnt;
  logic              w_b_gnt;

  // Ties go to whoever did not win last; reset biases the first tie toward A.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (!reset && r_state == ST_IDLE && !clear_req) begin
      if (a_req && (!b_req || r_last_b)) w_a_gnt = 1'b1;
      else if (b_req)                    w_b_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (!reset && r_state == ST_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = r_cnt;
    end else if (w_a_gnt) begin
      mem_we   = a_we;
      mem_addr = a_addr;
      mem_din  = a_wdata;
    end else if (w_b_gnt) begin
      mem_we   = b_we;
      mem_addr = b_addr;
      mem_din  = b_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_last_b <= 1'b1;
      r_cnt    <= '0;
      r_pend_a <= 1'b0;
      r_pend_b <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_pend_a <= w_a_gnt & ~a_we;
      r_pend_b <= w_b_gnt & ~b_we;
      r_done   <= 1'b0;
      if (w_a_gnt)      r_last_b <= 1'b0;
      else if (w_b_gnt) r_last_b <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (clear_req) r_state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM output is only meaningful the cycle after a read; zero it otherwise.
  assign a_gnt      = w_a_gnt;
  assign b_gnt      = w_b_gnt;
  assign a_rvalid   = r_pend_a;
  assign b_rvalid   = r_pend_b;
  assign rdata      = (r_pend_a | r_pend_b) ? mem_dout : '0;
  assign clear_busy = (r_state == ST_CLEAR);
  assign clear_done = r_done;

endmodule
